seg7_reader: RTL

- Reverse direction of the team's hex-to-7-segment decoder: samples an active-low 7-segment pattern (bit0 = segment a … bit6 = segment g) and recovers the 4-bit hex nibble.
- Requires the pattern to be stable for a set number of cycles, rejects illegal patterns, and hands each nibble downstream on a valid/ready handshake.
- Keeps a 4-digit history register for on-board score readback and self-check of display paths.

---
 rtl/seg7_reader.sv | 138 +++++++++++++
 1 files changed

// File: rtl/seg7_reader.sv
// seg7_reader: active-low 7-segment pattern to hex nibble, with settle filter.
// Define SEG7_BLANK_EN to treat 0x7F (all segments off) as a silent blank.
module seg7_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [6:0]  seg_in,
  input  logic        seg_strobe,
  output logic [3:0]  nib_out,
  output logic        nib_valid,
  input  logic        nib_ready,
  output logic        err,
  output logic [15:0] digits,
  output logic        busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [6:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       nib_q, nib_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [15:0]      dig_q, dig_d;
  logic             legal;
  logic [3:0]       dec;
  logic             blank;

  always_comb begin
    legal = 1'b1;
    dec   = 4'h0;
    case (cap_q)
      7'h40: dec = 4'h0;
      7'h79: dec = 4'h1;
      7'h24: dec = 4'h2;
      7'h30: dec = 4'h3;
      7'h19: dec = 4'h4;
      7'h12: dec = 4'h5;
      7'h02: dec = 4'h6;
      7'h78: dec = 4'h7;
      7'h00: dec = 4'h8;
      7'h10: dec = 4'h9;
      7'h08: dec = 4'hA;
      7'h03: dec = 4'hB;
      7'h46: dec = 4'hC;
      7'h21: dec = 4'hD;
      7'h06: dec = 4'hE;
      7'h0E: dec = 4'hF;
      default: legal = 1'b0;
    endcase
  end

`ifdef SEG7_BLANK_EN
  assign blank = (cap_q == 7'h7F);
`else
  assign blank = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    dig_d   = dig_q;
    unique case (state_q)
      IDLE: begin
        if (seg_strobe) begin
          cap_d   = seg_in;
          cnt_d   = CNT_W'(1);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (seg_in != cap_q) begin
          cap_d = seg_in;
          cnt_d = CNT_W'(1);
        end else if (cnt_inc < CNT_W'(STABLE_CYCLES)) begin
          cnt_d = cnt_inc;
        end else if (legal) begin
          nib_d   = dec;
          valid_d = 1'b1;
          state_d = EMIT;
        end else begin
          err_d   = ~blank;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (nib_ready) begin
          dig_d   = {dig_q[11:0], nib_q};
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cap_q   <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      dig_q   <= dig_d;
    end
  end

  assign nib_out   = nib_q;
  assign nib_valid = valid_q;
  assign err       = err_q;
  assign digits    = dig_q;
  assign busy      = (state_q != IDLE);

endmodule
